bf_jump_table_builder: RTL and testbench

//  Pre-execution pass for the BF CPU. After program load and before RUN, it scans program memory and

---
 rtl/bf_jump_table_builder_if.sv | 26 ++
 rtl/bf_jump_table_builder.sv | 156 +++++++++++++++
 tb/tb_bf_jump_table_builder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bf_jump_table_builder_if.sv
// Memory-side bus of the jump-table builder: program BRAM read port and jump-table BRAM write port.
interface bf_jump_table_builder_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [7:0]            prog_rd;
  logic                  jt_we;
  logic [ADDR_WIDTH-1:0] jt_addr;
  logic [ADDR_WIDTH-1:0] jt_data;

  modport master (
    output prog_addr,
    input  prog_rd,
    output jt_we,
    output jt_addr,
    output jt_data
  );

  modport slave (
    input  prog_addr,
    output prog_rd,
    input  jt_we,
    input  jt_addr,
    input  jt_data
  );
endinterface

// File: rtl/bf_jump_table_builder.sv
// Pre-run bracket matcher: scans program memory, pairs '[' with ']' through a LIFO,
// and writes both directions of each pair into the jump table.
module bf_jump_table_builder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned STACK_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  bf_jump_table_builder_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IDX_W = SP_W - 1;
  localparam logic [7:0]  CH_OPEN  = 8'h5B;
  localparam logic [7:0]  CH_CLOSE = 8'h5D;
  localparam logic [1:0]  ERR_CLOSE = 2'd1;
  localparam logic [1:0]  ERR_OPEN  = 2'd2;
  localparam logic [1:0]  ERR_OVF   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXAM, S_PAIR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [SP_W-1:0]       sp;
  logic [ADDR_WIDTH-1:0] open_addr;
  logic [ADDR_WIDTH-1:0] close_addr;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] top_c;
  logic                  is_last_c;
  logic                  stack_full_c;
  logic                  push_c;

  assign top_c        = stack[IDX_W'(sp - SP_W'(1))];
  assign is_last_c    = (bus.prog_addr == last_addr);
  assign stack_full_c = (sp == SP_W'(STACK_DEPTH));
  assign push_c       = (state == S_EXAM) && (bus.prog_rd == CH_OPEN) && !stack_full_c;

  // Stack storage needs no reset; only sp defines what is live.
  always_ff @(posedge clk) begin
    if (push_c) stack[IDX_W'(sp)] <= bus.prog_addr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      last_addr     <= '0;
      sp            <= '0;
      open_addr     <= '0;
      close_addr    <= '0;
      bus.prog_addr <= '0;
      bus.jt_we     <= 1'b0;
      bus.jt_addr   <= '0;
      bus.jt_data   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= '0;
      err_addr      <= '0;
    end else begin
      done      <= 1'b0;
      bus.jt_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            error    <= 1'b0;
            err_code <= '0;
            err_addr <= '0;
            if (prog_len == '0) begin
              done <= 1'b1;
            end else begin
              busy          <= 1'b1;
              last_addr     <= ADDR_WIDTH'(prog_len - (ADDR_WIDTH+1)'(1));
              bus.prog_addr <= '0;
              sp            <= '0;
              state         <= S_WAIT;
            end
          end
        end

        S_WAIT: state <= S_EXAM;

        S_EXAM: begin
          if (bus.prog_rd == CH_OPEN) begin
            if (stack_full_c) begin
              {error, err_code, err_addr, done, busy} <= {1'b1, ERR_OVF, bus.prog_addr, 1'b1, 1'b0};
              state <= S_IDLE;
            end else begin
              sp <= sp + SP_W'(1);
              // A '[' in the last slot is itself the innermost unmatched open.
              if (is_last_c) begin
                {error, err_code, err_addr, done, busy} <= {1'b1, ERR_OPEN, bus.prog_addr, 1'b1, 1'b0};
                state <= S_IDLE;
              end else begin
                bus.prog_addr <= bus.prog_addr + ADDR_WIDTH'(1);
                state         <= S_WAIT;
              end
            end
          end else if (bus.prog_rd == CH_CLOSE) begin
            if (sp == '0) begin
              {error, err_code, err_addr, done, busy} <= {1'b1, ERR_CLOSE, bus.prog_addr, 1'b1, 1'b0};
              state <= S_IDLE;
            end else begin
              sp          <= sp - SP_W'(1);
              open_addr   <= top_c;
              close_addr  <= bus.prog_addr;
              bus.jt_we   <= 1'b1;
              bus.jt_addr <= bus.prog_addr;
              bus.jt_data <= top_c;
              state       <= S_PAIR;
            end
          end else if (is_last_c) begin
            if (sp != '0) begin
              {error, err_code, err_addr, done, busy} <= {1'b1, ERR_OPEN, top_c, 1'b1, 1'b0};
            end else begin
              done <= 1'b1;
              busy <= 1'b0;
            end
            state <= S_IDLE;
          end else begin
            bus.prog_addr <= bus.prog_addr + ADDR_WIDTH'(1);
            state         <= S_WAIT;
          end
        end

        S_PAIR: begin
          bus.jt_we   <= 1'b1;
          bus.jt_addr <= open_addr;
          bus.jt_data <= close_addr;
          if (is_last_c) begin
            if (sp != '0) begin
              {error, err_code, err_addr, done, busy} <= {1'b1, ERR_OPEN, top_c, 1'b1, 1'b0};
            end else begin
              done <= 1'b1;
              busy <= 1'b0;
            end
            state <= S_IDLE;
          end else begin
            bus.prog_addr <= bus.prog_addr + ADDR_WIDTH'(1);
            state         <= S_WAIT;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_jump_table_builder.sv
// Directed bench for bf_jump_table_builder: vector table plus reset, mid-scan start and full-length corners.
module tb_bf_jump_table_builder;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW:0]   prog_len;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;

  bf_jump_table_builder_if #(.ADDR_WIDTH(AW)) bus ();

  bf_jump_table_builder #(.ADDR_WIDTH(AW), .STACK_DEPTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .prog_len (prog_len),
    .bus      (bus.master),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1 << AW];
  always @(posedge clk) bus.prog_rd <= mem[bus.prog_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  int overlap = 0;
  int lat;
  logic [19:0] wq[$];

  // Expected writes: entry k occupies w[20*k +: 20] as {addr, data}; entry 0 in the low bits.
  typedef struct {
    string        prog;
    int           len;
    int           nw;
    logic [159:0] w;
    int           lat;
    logic         err;
    logic [1:0]   code;
    logic [AW-1:0] eaddr;
  } vec_t;

  function automatic logic [19:0] pk(input int a, input int d);
    return {10'(a), 10'(d)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input string p);
    for (int i = 0; i < p.len(); i++) mem[i] = p[i];
  endtask

  // Start a scan and collect writes until done; optionally pulse start again mid-scan.
  task automatic run(input int len, input int pulse_at);
    int e0;
    bit seen;
    wq.delete();
    seen = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    prog_len = (AW+1)'(len);
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
    lat   = -1;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (i == pulse_at) begin
        start    = 1'b1;
        prog_len = '0;
      end else begin
        start = 1'b0;
      end
      if (bus.jt_we) wq.push_back({bus.jt_addr, bus.jt_data});
      if (busy && done) overlap++;
      if (done) begin
        lat  = cyc - e0;
        seen = 1'b1;
      end
    end
    start = 1'b0;
    if (!seen) chk("timeout", 0, 1);
  endtask

  task automatic check_writes(input string tag, input int nw, input logic [159:0] w);
    chk({tag, ".nwrites"}, wq.size(), nw);
    for (int k = 0; k < nw && k < wq.size(); k++)
      chk($sformatf("%s.write%0d", tag, k), int'(wq[k]), int'(w[20*k +: 20]));
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{"+[-].",    5, 2, {pk(1,3), pk(3,1)}, 11, 1'b0, 2'd0, 10'd0};
    vecs[1] = '{"[[]]",     4, 4, {pk(0,3), pk(3,0), pk(1,2), pk(2,1)}, 10, 1'b0, 2'd0, 10'd0};
    vecs[2] = '{"]",        1, 0, 160'd0, 2, 1'b1, 2'd1, 10'd0};
    vecs[3] = '{"[[+]",     4, 2, {pk(1,3), pk(3,1)}, 9, 1'b1, 2'd2, 10'd0};
    vecs[4] = '{"[[[[[",    5, 0, 160'd0, 10, 1'b1, 2'd3, 10'd4};
    vecs[5] = '{"[[[[]]]]", 8, 8, {pk(0,7), pk(7,0), pk(1,6), pk(6,1), pk(2,5), pk(5,2), pk(3,4), pk(4,3)},
                20, 1'b0, 2'd0, 10'd0};
    vecs[6] = '{"[]]",      3, 2, {pk(0,1), pk(1,0)}, 7, 1'b1, 2'd1, 10'd2};
    vecs[7] = '{"",         0, 0, 160'd0, 0, 1'b0, 2'd0, 10'd0};
    vecs[8] = '{"ab",       2, 0, 160'd0, 4, 1'b0, 2'd0, 10'd0};

    resetn   = 1'b0;
    start    = 1'b0;
    prog_len = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.error", error, 0);
    chk("rst.jt_we", bus.jt_we, 0);
    chk("rst.prog_addr", bus.prog_addr, 0);
    resetn = 1'b1;

    for (int v = 0; v < 9; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      load(vecs[v].prog);
      run(vecs[v].len, -1);
      chk({tag, ".latency"}, lat, vecs[v].lat);
      check_writes(tag, vecs[v].nw, vecs[v].w);
      chk({tag, ".error"}, error, vecs[v].err);
      chk({tag, ".err_code"}, err_code, vecs[v].code);
      chk({tag, ".err_addr"}, err_addr, vecs[v].eaddr);
      @(negedge clk);
      chk({tag, ".busy_after"}, busy, 0);
      chk({tag, ".done_pulse"}, done, 0);
    end

    // A start (with prog_len=0) during a scan must not end or disturb it.
    load("[[]]");
    run(4, 3);
    chk("midstart.latency", lat, 10);
    check_writes("midstart", 4, {pk(0,3), pk(3,0), pk(1,2), pk(2,1)});
    chk("midstart.error", error, 0);

    // Full address range: last address is all-ones.
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h2B;
    mem[0]    = 8'h5B;
    mem[1023] = 8'h5D;
    run(1024, -1);
    chk("full.latency", lat, 2049);
    check_writes("full", 2, {pk(0,1023), pk(1023,0)});
    chk("full.error", error, 0);

    // Reset mid-scan, then a fresh scan.
    load("]");
    run(1, -1);
    chk("pre_rst.error", error, 1);
    load("[[[[]]]]");
    @(negedge clk);
    start    = 1'b1;
    prog_len = 11'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid.busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.jt_we", bus.jt_we, 0);
    chk("midrst.prog_addr", bus.prog_addr, 0);
    chk("midrst.jt_addr", bus.jt_addr, 0);
    chk("midrst.error", error, 0);
    @(negedge clk);
    chk("midrst.done", done, 0);
    resetn = 1'b1;
    load("+[-].");
    run(5, -1);
    chk("rescan.latency", lat, 11);
    check_writes("rescan", 2, {pk(1,3), pk(3,1)});
    chk("rescan.error", error, 0);

    chk("busy_done_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
